// File: rtl/req_arbiter_4ch.sv
// Four-requester arbiter: registered one-hot grant held until done, request drop or MAX_HOLD timeout.
// Define ARB_ROUND_ROBIN_EN for rotating priority; otherwise fixed priority 3>2>1>0.
module req_arbiter_4ch #(
   parameter int unsigned MAX_HOLD = 16,
   parameter int unsigned CNT_W    = 5
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [3:0] req_i,
   input  logic [3:0] done_i,
   output logic [3:0] gnt_o,
   output logic [1:0] gnt_id_o,
   output logic       gnt_valid_o,
   output logic       timeout_o
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT   = 2'd1,
      RELEASE = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [3:0]       gnt_q, gnt_d;
   logic [1:0]       gnt_id_q, gnt_id_d;
   logic             gnt_valid_q, gnt_valid_d;
   logic             timeout_q, timeout_d;
   logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
   logic [1:0]       base;
   logic [1:0]       win;
   logic             owner_req, owner_done, at_max;

   // Search starts at base-1 and walks down mod 4; base itself is checked last.
   function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] b);
      logic [1:0] idx;
      pick = 2'd0;
      for (int k = 4; k >= 1; k--) begin
         idx = b - 2'(k);
         if (r[idx]) pick = idx;
      end
   endfunction

`ifdef ARB_ROUND_ROBIN_EN
   logic [1:0] last_id_q, last_id_d;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) last_id_q <= 2'd0;
      else       last_id_q <= last_id_d;
   end

   always_comb begin
      last_id_d = last_id_q;
      if (state_q == RELEASE) last_id_d = gnt_id_q;
   end

   assign base = last_id_q;
`else
   // base 0 yields the fixed order 3,2,1,0.
   assign base = 2'd0;
`endif

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         gnt_q       <= 4'd0;
         gnt_id_q    <= 2'd0;
         gnt_valid_q <= 1'b0;
         timeout_q   <= 1'b0;
         hold_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         gnt_q       <= gnt_d;
         gnt_id_q    <= gnt_id_d;
         gnt_valid_q <= gnt_valid_d;
         timeout_q   <= timeout_d;
         hold_cnt_q  <= hold_cnt_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      gnt_d       = gnt_q;
      gnt_id_d    = gnt_id_q;
      gnt_valid_d = gnt_valid_q;
      timeout_d   = 1'b0;
      hold_cnt_d  = hold_cnt_q;
      win         = pick(req_i, base);
      owner_req   = req_i[gnt_id_q];
      owner_done  = done_i[gnt_id_q];
      at_max      = (hold_cnt_q == CNT_W'(MAX_HOLD - 1));

      case (state_q)
         IDLE: begin
            gnt_d       = 4'd0;
            gnt_valid_d = 1'b0;
            hold_cnt_d  = '0;
            if (|req_i) begin
               gnt_d       = 4'b0001 << win;
               gnt_id_d    = win;
               gnt_valid_d = 1'b1;
               state_d     = GRANT;
            end
         end
         GRANT: begin
            if (owner_done || !owner_req || at_max) begin
               state_d     = RELEASE;
               gnt_d       = 4'd0;
               gnt_valid_d = 1'b0;
               // Pulse only when the limit alone ends the grant.
               timeout_d   = at_max && !owner_done && owner_req;
            end else if (!at_max) begin
               hold_cnt_d = hold_cnt_q + 1'b1;
            end
         end
         RELEASE: begin
            gnt_d       = 4'd0;
            gnt_valid_d = 1'b0;
            state_d     = IDLE;
         end
         default: begin
            gnt_d       = 4'd0;
            gnt_valid_d = 1'b0;
            state_d     = IDLE;
         end
      endcase
   end

   assign gnt_o       = gnt_q;
   assign gnt_id_o    = gnt_id_q;
   assign gnt_valid_o = gnt_valid_q;
   assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_req_arbiter_4ch.sv
// Randomized and directed bench for req_arbiter_4ch against a cycle-level behavioural model.
module tb_req_arbiter_4ch;
   localparam int MAX_HOLD = 16;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] req, done;
   logic [3:0] gnt_o;
   logic [1:0] gnt_id_o;
   logic       gnt_valid_o, timeout_o;

   int n_chk = 0;
   int n_err = 0;

   // model: phase 0 idle, 1 owner holds grant, 2 dead cycle
   int         m_phase, m_owner, m_held, m_last;
   logic [3:0] e_gnt;
   logic [1:0] e_id;
   logic       e_valid, e_to;

   always #5 clk = ~clk;

   req_arbiter_4ch #(.MAX_HOLD(MAX_HOLD), .CNT_W(5)) dut (
      .clk_i(clk), .rst_i(rst), .req_i(req), .done_i(done),
      .gnt_o(gnt_o), .gnt_id_o(gnt_id_o), .gnt_valid_o(gnt_valid_o), .timeout_o(timeout_o)
   );

   task automatic chk(input string tag, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s act=%0d exp=%0d", tag, act, exp);
      end
   endtask

   function automatic int choose(input logic [3:0] r, input int last);
      int order [4];
      for (int i = 0; i < 4; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
         order[i] = (last + 3 - i) % 4;
`else
         order[i] = 3 - i;
`endif
      end
      for (int i = 0; i < 4; i++)
         if (r[order[i]]) return order[i];
      return 0;
   endfunction

   task automatic m_reset();
      m_phase = 0; m_owner = 0; m_held = 0; m_last = 0;
      e_gnt = 4'd0; e_id = 2'd0; e_valid = 1'b0; e_to = 1'b0;
   endtask

   task automatic m_update(input logic [3:0] r, input logic [3:0] d);
      e_to = 1'b0;
      case (m_phase)
         0: if (r != 4'd0) begin
               m_owner = choose(r, m_last);
               m_held  = 1;
               m_phase = 1;
               e_gnt   = 4'd1 << m_owner;
               e_id    = 2'(m_owner);
               e_valid = 1'b1;
            end
         1: if (d[m_owner] || !r[m_owner] || m_held == MAX_HOLD) begin
               e_to    = (m_held == MAX_HOLD) && !d[m_owner] && r[m_owner];
               m_phase = 2;
               e_gnt   = 4'd0;
               e_valid = 1'b0;
            end else begin
               m_held++;
            end
         default: begin
            m_last  = m_owner;
            m_phase = 0;
         end
      endcase
   endtask

   task automatic cmp_all();
      chk("gnt", 32'(gnt_o), 32'(e_gnt));
      chk("gnt_valid", 32'(gnt_valid_o), 32'(e_valid));
      chk("timeout", 32'(timeout_o), 32'(e_to));
      if (e_valid) chk("gnt_id", 32'(gnt_id_o), 32'(e_id));
   endtask

   // called at a negedge; applies inputs, advances one clock, checks at next negedge
   task automatic step(input logic [3:0] r, input logic [3:0] d);
      req = r; done = d;
      @(posedge clk);
      m_update(r, d);
      @(negedge clk);
      cmp_all();
   endtask

   int         n_hold;
   int         got;
   int         exp_order [5];
   logic [3:0] rr, dd;

   initial begin
`ifdef ARB_ROUND_ROBIN_EN
      exp_order = '{3, 2, 1, 0, 3};
`else
      exp_order = '{3, 3, 3, 3, 3};
`endif
      rst = 1'b1; req = 4'd0; done = 4'd0;
      m_reset();
      repeat (2) @(negedge clk);
      chk("rst_gnt", 32'(gnt_o), 0);
      chk("rst_valid", 32'(gnt_valid_o), 0);
      chk("rst_id", 32'(gnt_id_o), 0);
      chk("rst_timeout", 32'(timeout_o), 0);
      rst = 1'b0;

      // priority pick with one-cycle latency
      step(4'b0101, 4'b0000);
      chk("t1_gnt", 32'(gnt_o), 32'(4'b0100));
      chk("t1_id", 32'(gnt_id_o), 2);
      chk("t1_valid", 32'(gnt_valid_o), 1);

      // owner 2 releases on its third grant cycle
      step(4'b0101, 4'b0000);
      step(4'b0101, 4'b0100);
      chk("t2_dead", 32'(gnt_o), 0);
      step(4'b0001, 4'b0000);
      chk("t2_arb", 32'(gnt_o), 0);
      step(4'b0001, 4'b0000);
      chk("t2_next", 32'(gnt_o), 32'(4'b0001));
      step(4'b0000, 4'b0001);
      step(4'b0000, 4'b0000);

      // forced release after MAX_HOLD cycles; non-owner done ignored throughout
      step(4'b1000, 4'b0001);
      n_hold = 0;
      for (int i = 0; i < 40 && gnt_o == 4'b1000; i++) begin
         n_hold++;
         step(4'b1000, 4'b0001);
      end
      chk("t3_hold_len", n_hold, MAX_HOLD);
      chk("t3_timeout", 32'(timeout_o), 1);
      step(4'b1000, 4'b0000);
      chk("t3_to_once", 32'(timeout_o), 0);
      step(4'b1000, 4'b0000);
      chk("t3_regrant", 32'(gnt_o), 32'(4'b1000));
      step(4'b1000, 4'b0000);

      // asynchronous reset between clock edges
      #2 rst = 1'b1;
      #1;
      chk("t4_gnt", 32'(gnt_o), 0);
      chk("t4_valid", 32'(gnt_valid_o), 0);
      chk("t4_timeout", 32'(timeout_o), 0);
      req = 4'd0; done = 4'd0;
      @(negedge clk);
      m_reset();
      rst = 1'b0;

      // all requesting, owner releases after each grant
      for (int g = 0; g < 5; g++) begin
         step(4'b1111, 4'b0000);
         got = int'(gnt_id_o);
         chk("t5_order", got, exp_order[g]);
         step(4'b1111, 4'(4'd1 << m_owner));
         step(4'b1111, 4'b0000);
      end
      step(4'b0000, 4'b0000);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         rr = 4'($urandom_range(0, 15));
         dd = 4'd0;
         if (m_phase == 1) begin
            rr[m_owner] = ($urandom_range(0, 31) != 0);
            dd = 4'($urandom_range(0, 15));
            dd[m_owner] = ($urandom_range(0, 31) == 0);
         end
         if ($urandom_range(0, 63) == 0) rr = 4'd0;
         step(rr, dd);
      end

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
